// File: rtl/axi_gran_burst_chunker.sv
// Request-side burst splitter. It accepts one AXI AR/AW request and reserves a
// beat counter for it through the alloc port. It then issues the request
// downstream as fragments of at most lim+1 beats. Only one original request is
// inside the block at a time. Every output is driven from a register.
module axi_gran_burst_chunker #(
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           len_limit_i,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  output logic [IdWidth-1:0]   alloc_id_o,
  output logic [7:0]           alloc_len_o,
  output logic                 alloc_req_o,
  input  logic                 alloc_gnt_i,
  output logic [IdWidth-1:0]   frag_id_o,
  output logic [AddrWidth-1:0] frag_addr_o,
  output logic [7:0]           frag_len_o,
  output logic [2:0]           frag_size_o,
  output logic [1:0]           frag_burst_o,
  output logic                 frag_last_o,
  output logic                 frag_valid_o,
  input  logic                 frag_ready_i,
  output logic                 busy_o
);

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                 state;
  logic [IdWidth-1:0]     id_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             len_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic [7:0]             lim_q;
  logic [7:0]             rem_q;
  logic                   ready_q;
  logic                   alloc_req_q;
  logic                   frag_valid_q;
  logic [7:0]             frag_len_q;
  logic                   frag_last_q;

  // The remaining-beat count after this fragment. It is only used when
  // rem > lim. In that case lim < 255, so the subtraction cannot underflow.
  logic [7:0]             rem_next;
  // The byte step between fragments. It only advances INCR bursts.
  logic [AddrWidth-1:0]   addr_step;
  logic [8:0]             frag_after;

  // Compute the {last, len} of a fragment from the remaining beats. WRAP
  // bursts are never split. A limit of 255 always yields one fragment.
  function automatic logic [8:0] frag_calc(input logic [7:0] rem,
                                           input logic [7:0] lim,
                                           input logic [1:0] burst);
    logic [8:0] res;
    if (burst == BurstWrap || rem <= lim) begin
      res = {1'b1, rem};
    end else begin
      res = {1'b0, lim};
    end
    return res;
  endfunction

  // Compute the next fragment's remaining count and the address step.
  always_comb begin
    rem_next   = rem_q - lim_q - 8'd1;
    addr_step  = (AddrWidth'(lim_q) + AddrWidth'(1)) << size_q;
    frag_after = frag_calc(rem_next, lim_q, burst_q);
  end

  // Request FSM. A request is accepted, then a counter is allocated, then
  // fragments are issued. All handshake outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      lim_q        <= '0;
      rem_q        <= '0;
      ready_q      <= 1'b0;
      alloc_req_q  <= 1'b0;
      frag_valid_q <= 1'b0;
      frag_len_q   <= '0;
      frag_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready_q && ax_valid_i) begin
            id_q        <= ax_id_i;
            addr_q      <= ax_addr_i;
            len_q       <= ax_len_i;
            size_q      <= ax_size_i;
            burst_q     <= ax_burst_i;
            lim_q       <= len_limit_i;
            rem_q       <= ax_len_i;
            ready_q     <= 1'b0;
            alloc_req_q <= 1'b1;
            state       <= ALLOC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ALLOC: begin
          if (alloc_gnt_i) begin
            alloc_req_q                <= 1'b0;
            frag_valid_q               <= 1'b1;
            {frag_last_q, frag_len_q}  <= frag_calc(rem_q, lim_q, burst_q);
            state                      <= ISSUE;
          end
        end
        ISSUE: begin
          if (frag_ready_i) begin
            if (frag_last_q) begin
              frag_valid_q <= 1'b0;
              ready_q      <= 1'b1;
              state        <= IDLE;
            end else begin
              rem_q                     <= rem_next;
              {frag_last_q, frag_len_q} <= frag_after;
              if (burst_q == BurstIncr) begin
                addr_q <= addr_q + addr_step;
              end else if (burst_q == BurstFixed) begin
                addr_q <= addr_q;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ax_ready_o   = ready_q;
  assign alloc_id_o   = id_q;
  assign alloc_len_o  = len_q;
  assign alloc_req_o  = alloc_req_q;
  assign frag_id_o    = id_q;
  assign frag_addr_o  = addr_q;
  assign frag_len_o   = frag_len_q;
  assign frag_size_o  = size_q;
  assign frag_burst_o = burst_q;
  assign frag_last_o  = frag_last_q;
  assign frag_valid_o = frag_valid_q;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_axi_gran_burst_chunker.sv
// Directed testbench for axi_gran_burst_chunker. The expected values are
// worked out by hand from each request.
module tb_axi_gran_burst_chunker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  len_limit_i;
  logic [3:0]  ax_id_i;
  logic [31:0] ax_addr_i;
  logic [7:0]  ax_len_i;
  logic [2:0]  ax_size_i;
  logic [1:0]  ax_burst_i;
  logic        ax_valid_i;
  logic        ax_ready_o;
  logic [3:0]  alloc_id_o;
  logic [7:0]  alloc_len_o;
  logic        alloc_req_o;
  logic        alloc_gnt_i;
  logic [3:0]  frag_id_o;
  logic [31:0] frag_addr_o;
  logic [7:0]  frag_len_o;
  logic [2:0]  frag_size_o;
  logic [1:0]  frag_burst_o;
  logic        frag_last_o;
  logic        frag_valid_o;
  logic        frag_ready_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  axi_gran_burst_chunker #(.IdWidth(4), .AddrWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .len_limit_i(len_limit_i),
    .ax_id_i(ax_id_i), .ax_addr_i(ax_addr_i), .ax_len_i(ax_len_i),
    .ax_size_i(ax_size_i), .ax_burst_i(ax_burst_i), .ax_valid_i(ax_valid_i),
    .ax_ready_o(ax_ready_o), .alloc_id_o(alloc_id_o), .alloc_len_o(alloc_len_o),
    .alloc_req_o(alloc_req_o), .alloc_gnt_i(alloc_gnt_i), .frag_id_o(frag_id_o),
    .frag_addr_o(frag_addr_o), .frag_len_o(frag_len_o), .frag_size_o(frag_size_o),
    .frag_burst_o(frag_burst_o), .frag_last_o(frag_last_o),
    .frag_valid_o(frag_valid_o), .frag_ready_i(frag_ready_i), .busy_o(busy_o)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk_i = ~clk_i;

  // Advance one cycle. Inputs are driven, and outputs sampled, 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for ax_ready_o, with a bound. Then present one request for exactly one cycle.
  // Afterwards the allocation request must be up with the original id and len.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [7:0] lim);
    int n = 0;
    while (ax_ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ax_ready_before_req", ax_ready_o, 1);
    ax_id_i = id; ax_addr_i = addr; ax_len_i = len; ax_size_i = size;
    ax_burst_i = burst; len_limit_i = lim; ax_valid_i = 1'b1;
    tick();
    ax_valid_i = 1'b0;
    checkOutput("alloc_req_up", alloc_req_o, 1);
    checkOutput("alloc_id", alloc_id_o, id);
    checkOutput("alloc_len", alloc_len_o, len);
    checkOutput("ax_ready_low", ax_ready_o, 0);
  endtask

  task automatic grant();
    alloc_gnt_i = 1'b1;
    tick();
    alloc_gnt_i = 1'b0;
    checkOutput("alloc_req_dropped", alloc_req_o, 0);
    checkOutput("frag_valid_up", frag_valid_o, 1);
  endtask

  // Check the current fragment, then handshake it in one cycle.
  task automatic expectFrag(input string tag, input logic [31:0] addr,
                            input logic [7:0] len, input logic last);
    checkOutput({tag, "_valid"}, frag_valid_o, 1);
    checkOutput({tag, "_addr"}, frag_addr_o, addr);
    checkOutput({tag, "_len"}, frag_len_o, len);
    checkOutput({tag, "_last"}, frag_last_o, last);
    frag_ready_i = 1'b1;
    tick();
    frag_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; len_limit_i = 8'd0; ax_id_i = '0; ax_addr_i = '0;
    ax_len_i = '0; ax_size_i = '0; ax_burst_i = '0; ax_valid_i = 1'b0;
    alloc_gnt_i = 1'b0; frag_ready_i = 1'b0;
    tick(); tick();
    checkOutput("rst_ax_ready", ax_ready_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_alloc_req", alloc_req_o, 0);
    checkOutput("rst_frag_valid", frag_valid_o, 0);
    rst_i = 1'b0;
    tick();
    checkOutput("idle_ax_ready", ax_ready_o, 1);

    // INCR 0x1000 len15 size2 lim3: 4 fragments 16 bytes apart, one per cycle
    applyStimulus(4'h5, 32'h1000, 8'd15, 3'd2, 2'd1, 8'd3);
    checkOutput("busy_alloc", busy_o, 1);
    grant();
    checkOutput("frag_id", frag_id_o, 4'h5);
    checkOutput("frag_size", frag_size_o, 2);
    checkOutput("frag_burst", frag_burst_o, 1);
    frag_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_valid", frag_valid_o, 1);
      checkOutput("t1_addr", frag_addr_o, 32'h1000 + 32'(i) * 32'h10);
      checkOutput("t1_len", frag_len_o, 3);
      checkOutput("t1_last", frag_last_o, (i == 3) ? 1 : 0);
      tick();
    end
    frag_ready_i = 1'b0;
    checkOutput("t1_ready_after", ax_ready_o, 1);
    checkOutput("t1_valid_after", frag_valid_o, 0);
    checkOutput("t1_busy_after", busy_o, 0);

    // INCR len5 lim3 size3 at 0x0
    applyStimulus(4'h1, 32'h0, 8'd5, 3'd3, 2'd1, 8'd3);
    grant();
    expectFrag("t2a", 32'h0, 8'd3, 1'b0);
    expectFrag("t2b", 32'h20, 8'd1, 1'b1);

    // WRAP len7 lim1: never split
    applyStimulus(4'h2, 32'h40, 8'd7, 3'd2, 2'd2, 8'd1);
    grant();
    expectFrag("t3", 32'h40, 8'd7, 1'b1);
    checkOutput("t3_idle", ax_ready_o, 1);

    // FIXED len3 lim0: 4 single-beat fragments, same address
    applyStimulus(4'h3, 32'h80, 8'd3, 3'd2, 2'd0, 8'd0);
    grant();
    expectFrag("t4a", 32'h80, 8'd0, 1'b0);
    expectFrag("t4b", 32'h80, 8'd0, 1'b0);
    expectFrag("t4c", 32'h80, 8'd0, 1'b0);
    expectFrag("t4d", 32'h80, 8'd0, 1'b1);

    // lim=255: a single pass-through fragment
    applyStimulus(4'h4, 32'h300, 8'd200, 3'd2, 2'd1, 8'd255);
    grant();
    expectFrag("t5", 32'h300, 8'd200, 1'b1);

    // Address wraps modulo 2^32: step 8, fragments at F0, F8, 0x0
    applyStimulus(4'h6, 32'hFFFF_FFF0, 8'd5, 3'd2, 2'd1, 8'd1);
    grant();
    expectFrag("t6a", 32'hFFFF_FFF0, 8'd1, 1'b0);
    expectFrag("t6b", 32'hFFFF_FFF8, 8'd1, 1'b0);
    expectFrag("t6c", 32'h0000_0000, 8'd1, 1'b1);

    // Grant held off for 10 cycles. A competing valid request must be ignored.
    applyStimulus(4'h7, 32'h500, 8'd9, 3'd0, 2'd1, 8'd4);
    ax_valid_i = 1'b1; ax_len_i = 8'd1; ax_id_i = 4'hA;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t7_req_held", alloc_req_o, 1);
      checkOutput("t7_len_held", alloc_len_o, 9);
      checkOutput("t7_id_held", alloc_id_o, 4'h7);
      checkOutput("t7_no_frag", frag_valid_o, 0);
      checkOutput("t7_not_ready", ax_ready_o, 0);
    end
    ax_valid_i = 1'b0;
    grant();
    expectFrag("t7a", 32'h500, 8'd4, 1'b0);
    expectFrag("t7b", 32'h505, 8'd4, 1'b1);

    // Stall the second fragment for 5 cycles while len_limit_i changes.
    applyStimulus(4'h8, 32'h2000, 8'd7, 3'd0, 2'd1, 8'd1);
    grant();
    expectFrag("t8a", 32'h2000, 8'd1, 1'b0);
    len_limit_i = 8'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t8_stall_valid", frag_valid_o, 1);
      checkOutput("t8_stall_addr", frag_addr_o, 32'h2002);
      checkOutput("t8_stall_len", frag_len_o, 1);
      checkOutput("t8_stall_last", frag_last_o, 0);
    end
    expectFrag("t8b", 32'h2002, 8'd1, 1'b0);
    expectFrag("t8c", 32'h2004, 8'd1, 1'b0);
    expectFrag("t8d", 32'h2006, 8'd1, 1'b1);

    // Pulse reset during ISSUE. The burst is dropped.
    applyStimulus(4'h9, 32'h4000, 8'd15, 3'd2, 2'd1, 8'd3);
    grant();
    expectFrag("t9a", 32'h4000, 8'd3, 1'b0);
    rst_i = 1'b1;
    #1;
    checkOutput("t9_rst_valid", frag_valid_o, 0);
    checkOutput("t9_rst_addr", frag_addr_o, 0);
    checkOutput("t9_rst_len", frag_len_o, 0);
    checkOutput("t9_rst_ready", ax_ready_o, 0);
    checkOutput("t9_rst_busy", busy_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    checkOutput("t9_post_ready", ax_ready_o, 1);
    checkOutput("t9_post_busy", busy_o, 0);
    checkOutput("t9_post_valid", frag_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
